instruction_fetch_ctrl: RTL

//  Fetch sequencer directly downstream of the program-counter register.

---
 rtl/instruction_fetch_ctrl_pkg.sv | 16 +
 rtl/instruction_fetch_ctrl_if.sv | 34 +++
 rtl/instruction_fetch_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/instruction_fetch_ctrl_pkg.sv
// Shared fetch definitions: state encoding and
// HALT opcode defaults, also used by the decoder.
package instruction_fetch_ctrl_pkg;

  localparam int unsigned OPC_LEN_DEF = 4;
  localparam logic [3:0] HALT_OPCODE_DEF = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_HOLD   = 3'd3,
    S_HALTED = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_ctrl_if.sv
// Fetch bundle: PC link, instruction memory port
// and the IR valid/ready channel towards decode.
interface instruction_fetch_ctrl_if #(
  parameter int DATA_LEN = 16,
  parameter int ADDR_LEN = 16
);

  logic                start;
  logic                flush;
  logic [ADDR_LEN-1:0] pc_value;
  logic                pc_inc;
  logic [ADDR_LEN-1:0] imem_addr;
  logic                imem_rd_en;
  logic [DATA_LEN-1:0] imem_data;
  logic [DATA_LEN-1:0] ir_out;
  logic                ir_valid;
  logic                ir_ready;
  logic                halted;

  modport master (
    input  start, flush, pc_value,
    input  imem_data, ir_ready,
    output pc_inc, imem_addr, imem_rd_en,
    output ir_out, ir_valid, halted
  );

  modport slave (
    output start, flush, pc_value,
    output imem_data, ir_ready,
    input  pc_inc, imem_addr, imem_rd_en,
    input  ir_out, ir_valid, halted
  );

endinterface

// File: rtl/instruction_fetch_ctrl.sv
// Fetch sequencer: PC -> fixed-latency imem read
// -> IR, handed to decode over valid/ready.
module instruction_fetch_ctrl
  import instruction_fetch_ctrl_pkg::*;
#(
  parameter int DATA_LEN    = 16,
  parameter int ADDR_LEN    = 16,
  parameter int MEM_LATENCY = 2,
  parameter int OPC_LEN     = OPC_LEN_DEF,
  parameter logic [OPC_LEN-1:0] HALT_OPCODE =
    HALT_OPCODE_DEF
) (
  input logic clk,
  input logic reset,
  instruction_fetch_ctrl_if.master bus
);

  localparam int LAT_W = $clog2(MEM_LATENCY) + 1;

  fetch_state_e        state_q, state_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [DATA_LEN-1:0] ir_q, ir_d;
  logic                vld_q, vld_d;

  logic lat_zero;
  logic capture;
  logic is_halt;
  logic active;

  assign lat_zero = (lat_q == '0);
  assign capture  = (state_q == S_WAIT) &&
                    lat_zero && !bus.flush;
  assign is_halt  =
    (ir_q[DATA_LEN-1 -: OPC_LEN] == HALT_OPCODE);
  assign active   = (state_q == S_ISSUE) ||
                    (state_q == S_WAIT)  ||
                    (state_q == S_HOLD);

  // Strobes stay combinational so reset kills them
  // immediately, before the next clock edge.
  assign bus.imem_addr  = bus.pc_value;
  assign bus.imem_rd_en = (state_q == S_ISSUE);
  assign bus.pc_inc     = capture;
  assign bus.halted     = (state_q == S_HALTED);
  assign bus.ir_out     = ir_q;
  assign bus.ir_valid   = vld_q;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    ir_d    = ir_q;
    vld_d   = vld_q;
    unique case (state_q)
      S_IDLE, S_HALTED: begin
        if (bus.start) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        lat_d   = LAT_W'(MEM_LATENCY - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lat_zero) begin
          ir_d    = bus.imem_data;
          vld_d   = 1'b1;
          state_d = S_HOLD;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (bus.ir_ready) begin
          vld_d   = 1'b0;
          state_d = is_halt ? S_HALTED : S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Branch reload beats capture and handshake.
    if (bus.flush && active) begin
      state_d = S_ISSUE;
      ir_d    = ir_q;
      vld_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
      ir_q    <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      ir_q    <= ir_d;
      vld_q   <= vld_d;
    end
  end

endmodule
